// File: rtl/div_arbiter.sv
// div_arbiter
//
// Shares one iterative divider between two requesters (ports 0 and 1).
// Arbitration is round-robin. A tie goes to the port that was not granted
// last time. After reset, port 0 wins the first tie.
//
// Sequence: IDLE grants a request and latches its operands. ISSUE pulses
// div_start for one cycle. WAIT waits for div_done. RESP returns the result
// to the granted port with a one-cycle ack.
//
// A zero divisor is resolved locally and the divider is not used. The
// result is q = all ones, r = dividend, err = 1.
//
// Each port's q/r/err outputs change only on the cycle that port's ack
// rises. They hold their value until that port's next ack.
//
// Optional build macro: DIV_TIMEOUT_EN
//   When it is defined, WAIT gives up after TIMEOUT cycles without div_done
//   and returns q=0, r=0, err=1. If div_done arrives on the expiring cycle,
//   div_done wins. When it is undefined, WAIT holds indefinitely and no
//   counter is built.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous, active-low
//   req0/a0/b0             port 0 request, dividend, divisor
//   ack0/q0/r0/err0        port 0 ack pulse, quotient, remainder, error
//   req1/a1/b1             port 1 request, dividend, divisor
//   ack1/q1/r1/err1        port 1 ack pulse, quotient, remainder, error
//   div_start              one-cycle start pulse to the divider
//   div_a/div_b            registered dividend/divisor to the divider
//   div_done/div_q/div_r   divider completion and result
module div_arbiter #(
    parameter int W       = 4,
    parameter int TIMEOUT = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    output logic         ack0,
    output logic [W-1:0] q0,
    output logic [W-1:0] r0,
    output logic         err0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack1,
    output logic [W-1:0] q1,
    output logic [W-1:0] r1,
    output logic         err1,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("div_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic           last_grant;
    logic           gid;
    logic           take;
    logic           grant_id;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   res_q;
    logic [W-1:0]   res_r;
    logic           res_err;
    logic           expired;

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  tmo_cnt;
    assign expired = (tmo_cnt == CW'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    // Arbitration and next-state logic.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        // A tie goes to the port that was not granted last. Otherwise the
        // single active requester is chosen.
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
        a_sel = grant_id ? a1 : a0;
        b_sel = grant_id ? b1 : b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    state_next = (b_sel == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (div_done || expired) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath. The result is staged in res_* and copied to the granted
    // port in RESP. That way a port's outputs move only together with its ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
            gid        <= 1'b0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            res_q      <= '0;
            res_r      <= '0;
            res_err    <= 1'b0;
            ack0       <= 1'b0;
            q0         <= '0;
            r0         <= '0;
            err0       <= 1'b0;
            ack1       <= 1'b0;
            q1         <= '0;
            r1         <= '0;
            err1       <= 1'b0;
        end else begin
            div_start <= (state == ISSUE);
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        div_a      <= a_sel;
                        div_b      <= b_sel;
                        last_grant <= grant_id;
                        gid        <= grant_id;
                        if (b_sel == '0) begin
                            res_q   <= '1;
                            res_r   <= a_sel;
                            res_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        res_q   <= div_q;
                        res_r   <= div_r;
                        res_err <= 1'b0;
                    end else if (expired) begin
                        res_q   <= '0;
                        res_r   <= '0;
                        res_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (gid) begin
                        ack1 <= 1'b1;
                        q1   <= res_q;
                        r1   <= res_r;
                        err1 <= res_err;
                    end else begin
                        ack0 <= 1'b1;
                        q0   <= res_q;
                        r0   <= res_r;
                        err0 <= res_err;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_TIMEOUT_EN
    // The counter is zero whenever WAIT is entered and counts the WAIT
    // cycles that have elapsed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

endmodule
